// File: rtl/user_io_arbiter.sv
// Round-robin arbiter sharing the mprj IO bank among NREQ requesters.
// Wishbone-programmed enable/mask, per-grant hold limit, sticky timeout flags and irq.
module user_io_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IO_W  = 38,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    input  logic                 wbs_stb_i,
    input  logic                 wbs_cyc_i,
    input  logic                 wbs_we_i,
    input  logic [3:0]           wbs_sel_i,
    input  logic [31:0]          wbs_adr_i,
    input  logic [31:0]          wbs_dat_i,
    output logic                 wbs_ack_o,
    output logic [31:0]          wbs_dat_o,
    input  logic [NREQ-1:0]      req_i,
    output logic [NREQ-1:0]      gnt_o,
    input  logic [NREQ*IO_W-1:0] req_out_i,
    input  logic [NREQ*IO_W-1:0] req_oeb_i,
    output logic [IO_W-1:0]      io_out_o,
    output logic [IO_W-1:0]      io_oeb_o,
    output logic                 irq_o
);

    localparam int unsigned OW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, COOL} state_t;

    state_t            state, state_n;
    logic              enable;
    logic [NREQ-1:0]   mask, lock, flags;
    logic [CNT_W-1:0]  limit, cnt, cnt_n;
    logic [OW-1:0]     owner, owner_n, rr_last, rr_n, pick;
    logic              found;
    logic [NREQ-1:0]   eligible, to_set, w1c;
    logic              acc, wr;
    logic [31:0]       rdata;
    logic              unused_ok;

    assign unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i, wbs_dat_i};

    assign acc      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o;
    assign wr       = acc & wbs_we_i;
    assign w1c      = (wr && wbs_adr_i[3:2] == 2'd3) ? wbs_dat_i[NREQ-1:0] : '0;
    assign eligible = req_i & mask & {NREQ{enable}} & ~lock;

    // Register read mux; unused bits read as zero.
    always_comb begin
        rdata = '0;
        case (wbs_adr_i[3:2])
            2'd0: begin
                rdata[0]         = enable;
                rdata[8 +: NREQ] = mask;
            end
            2'd1: rdata[CNT_W-1:0] = limit;
            2'd2: begin
                rdata[2:0]       = 3'(owner);
                rdata[4]         = (state == GRANT);
                rdata[8 +: NREQ] = lock;
            end
            default: rdata[NREQ-1:0] = flags;
        endcase
    end

    // First eligible requester after the last winner, wrapping around.
    always_comb begin : pick_p
        int unsigned idx;
        idx   = 0;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = 32'(rr_last) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && eligible[OW'(idx)]) begin
                found = 1'b1;
                pick  = OW'(idx);
            end
        end
    end

    always_comb begin
        state_n  = state;
        owner_n  = owner;
        rr_n     = rr_last;
        cnt_n    = cnt;
        to_set   = '0;
        gnt_o    = '0;
        io_out_o = '0;
        io_oeb_o = '1;
        case (state)
            IDLE: begin
                if (found) begin
                    owner_n = pick;
                    rr_n    = pick;
                    cnt_n   = '0;
                    state_n = GRANT;
                end
            end
            GRANT: begin
                gnt_o[owner] = 1'b1;
                io_out_o     = req_out_i[32'(owner)*IO_W +: IO_W];
                io_oeb_o     = req_oeb_i[32'(owner)*IO_W +: IO_W];
                if (cnt != '1) cnt_n = cnt + CNT_W'(1);
                // Timeout takes priority over an ordinary release.
                if (limit != '0 && cnt == limit - CNT_W'(1)) begin
                    to_set[owner] = 1'b1;
                    state_n       = COOL;
                end else if (!req_i[owner] || !mask[owner] || !enable) begin
                    state_n = COOL;
                end
            end
            COOL:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n_i) begin
            state     <= IDLE;
            owner     <= '0;
            rr_last   <= OW'(NREQ - 1);
            cnt       <= '0;
            enable    <= 1'b0;
            mask      <= '0;
            limit     <= '0;
            flags     <= '0;
            lock      <= '0;
            irq_o     <= 1'b0;
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
        end else begin
            state     <= state_n;
            owner     <= owner_n;
            rr_last   <= rr_n;
            cnt       <= cnt_n;
            lock      <= (lock & req_i) | to_set;
            flags     <= (flags & ~w1c) | to_set;
            irq_o     <= |flags;
            wbs_ack_o <= acc;
            wbs_dat_o <= acc ? rdata : '0;
            if (wr) begin
                case (wbs_adr_i[3:2])
                    2'd0: begin
                        enable <= wbs_dat_i[0];
                        mask   <= wbs_dat_i[8 +: NREQ];
                    end
                    2'd1:    limit <= wbs_dat_i[CNT_W-1:0];
                    default: ;
                endcase
            end
        end
    end

endmodule
